// File: rtl/exec_control.sv
// Execute-stage sequencer: issues ALU and branch operations to the datapath and runs a multiply on an internal shift-add accumulator.
// Latency: one cycle from accept to a valid result for ALU and branch operations, and MUL_STEPS cycles for a multiply.
// Backpressure: a result stays in HOLD, with every out_* output stable, until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   in_valid/in_ready              issue handshake
//   in_class/in_aluop/in_brne      operation class, ALU code and branch sense
//   in_a/in_b                      multiplicand and multiplier
//   alu_ctrl/sel                   datapath ALU control and operand mux select
//   zero/alu_res/target            datapath feedback
//   out_valid/out_ready            result handshake
//   out_result/out_target/out_taken result payload
//   busy                           high whenever not IDLE
module exec_control #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_class,
  input  logic [3:0]      in_aluop,
  input  logic            in_brne,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [3:0]      alu_ctrl,
  output logic            sel,
  input  logic            zero,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_target,
  output logic            out_taken,
  output logic            busy
);

  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_BR   = 3'd2,
    S_MUL  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]      cls_q;
  logic [3:0]      aluop_q;
  logic            brne_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            mul_last;
  logic [XLEN-1:0] acc_sum;

  // Gating with rst keeps in_ready low for the whole reset cycle, even
  // though the state register only clears at the edge.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

  assign mul_last  = (cnt_q == CW'(MUL_STEPS - 1));
  // One shift-add step; the final step's sum goes straight to out_result.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_ctrl  = 4'b0000;
    sel       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (in_class)
            2'b10:   state_nxt = S_BR;
            2'b11:   state_nxt = S_MUL;
            default: state_nxt = S_ALU;
          endcase
        end
      end
      S_ALU: begin
        alu_ctrl  = aluop_q;
        sel       = (cls_q == 2'b01);
        state_nxt = S_HOLD;
      end
      S_BR: begin
        alu_ctrl  = 4'b0110;
        state_nxt = S_HOLD;
      end
      S_MUL: begin
        if (mul_last) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q      <= '0;
      aluop_q    <= '0;
      brne_q     <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_result <= '0;
      out_target <= '0;
      out_taken  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cls_q    <= in_class;
            aluop_q  <= in_aluop;
            brne_q   <= in_brne;
            mcand_q  <= in_a;
            mplier_q <= in_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_ALU: begin
          out_result <= alu_res;
          out_taken  <= 1'b0;
          out_target <= '0;
        end
        S_BR: begin
          // The SUB result is zero exactly when the operands are equal.
          out_taken  <= zero ^ brne_q;
          out_target <= target;
          out_result <= '0;
        end
        S_MUL: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (mul_last) begin
            out_result <= acc_sum;
            out_taken  <= 1'b0;
            out_target <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
